// File: rtl/c1908_lock_pkg.sv
// rtl/c1908_lock_pkg.sv - shared constants and state type for the c1908 key sequencer
package c1908_lock_pkg;

  localparam int KEY_W = 54;
  localparam int PI_W  = 33;
  localparam int PO_W  = 25;

  localparam int CNT_W = 6;
  localparam int TRY_W = 3;
  localparam int SET_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SETTLE   = 3'd2,
    CHECK    = 3'd3,
    UNLOCKED = 3'd4,
    FAIL     = 3'd5,
    LOCKOUT  = 3'd6
  } state_e;

endpackage

// File: rtl/c1908_key_shreg.sv
// rtl/c1908_key_shreg.sv - serial-in key shadow register with bit counter and done pulse
module c1908_key_shreg
  import c1908_lock_pkg::*;
#(
  parameter int W = 54
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic         bit_i,
  output logic [W-1:0] next_o,
  output logic         done_o
);

  logic [W-1:0]     shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bits enter at the top and walk down, so the first accepted bit ends at index 0.
  assign next_o = {bit_i, shadow_q[W-1:1]};
  assign done_o = shift_i && (cnt_q == CNT_W'(W - 1));

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      shadow_d = '0;
      cnt_d    = '0;
    end else if (shift_i) begin
      shadow_d = next_o;
      cnt_d    = done_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/c1908_key_sequencer.sv
// rtl/c1908_key_sequencer.sv - key load, known-answer check and I/O gating for the locked c1908 core
module c1908_key_sequencer #(
  parameter int          KEY_W      = 54,
  parameter int          PI_W       = 33,
  parameter int          PO_W       = 25,
  parameter logic [32:0] CHK_VEC    = 33'h0,
  parameter logic [24:0] CHK_RESP   = 25'h0,
  parameter int          SETTLE_CYC = 2,
  parameter int          MAX_TRIES  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_bit,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic [PI_W-1:0]  core_pi,
  input  logic [PO_W-1:0]  core_po,
  input  logic [PI_W-1:0]  func_pi,
  output logic [PO_W-1:0]  func_po,
  output logic             busy,
  output logic             unlocked,
  output logic             fail,
  output logic             lockout
);

  localparam int SET_W = c1908_lock_pkg::SET_W;
  localparam int TRY_W = c1908_lock_pkg::TRY_W;

  typedef c1908_lock_pkg::state_e state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [KEY_W-1:0]   key_out_q, key_out_d;
  logic               key_ready_q, busy_q, unlocked_q, fail_q, lockout_q;

  logic               sh_clr, sh_shift, sh_done;
  logic [KEY_W-1:0]   sh_next;

  assign sh_clr   = start && ((state_q == c1908_lock_pkg::IDLE) || (state_q == c1908_lock_pkg::FAIL));
  assign sh_shift = (state_q == c1908_lock_pkg::LOAD) && key_valid;

  c1908_key_shreg #(
    .W(KEY_W)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sh_clr),
    .shift_i (sh_shift),
    .bit_i   (key_bit),
    .next_o  (sh_next),
    .done_o  (sh_done)
  );

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    tries_d   = tries_q;
    key_out_d = key_out_q;
    case (state_q)
      c1908_lock_pkg::IDLE: begin
        if (start) state_d = c1908_lock_pkg::LOAD;
      end
      c1908_lock_pkg::LOAD: begin
        if (sh_done) begin
          key_out_d = sh_next;
          settle_d  = SET_W'(SETTLE_CYC);
          state_d   = c1908_lock_pkg::SETTLE;
        end
      end
      c1908_lock_pkg::SETTLE: begin
        if (settle_q <= SET_W'(1)) state_d = c1908_lock_pkg::CHECK;
        else                       settle_d = settle_q - 1'b1;
      end
      c1908_lock_pkg::CHECK: begin
        if (core_po == CHK_RESP) begin
          state_d = c1908_lock_pkg::UNLOCKED;
        end else begin
          tries_d = tries_q + 1'b1;
          state_d = (tries_d == TRY_W'(MAX_TRIES)) ? c1908_lock_pkg::LOCKOUT
                                                   : c1908_lock_pkg::FAIL;
        end
      end
      c1908_lock_pkg::FAIL: begin
        if (start) state_d = c1908_lock_pkg::LOAD;
      end
      c1908_lock_pkg::UNLOCKED, c1908_lock_pkg::LOCKOUT: ;
      default: state_d = c1908_lock_pkg::IDLE;
    endcase
    // A locked-out part must never present a key to the core, including the entry edge.
    if (state_d == c1908_lock_pkg::LOCKOUT) key_out_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= c1908_lock_pkg::IDLE;
      settle_q    <= '0;
      tries_q     <= '0;
      key_out_q   <= '0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      unlocked_q  <= 1'b0;
      fail_q      <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      tries_q     <= tries_d;
      key_out_q   <= key_out_d;
      key_ready_q <= (state_d == c1908_lock_pkg::LOAD);
      busy_q      <= (state_d == c1908_lock_pkg::LOAD) || (state_d == c1908_lock_pkg::SETTLE) ||
                     (state_d == c1908_lock_pkg::CHECK);
      unlocked_q  <= (state_d == c1908_lock_pkg::UNLOCKED);
      fail_q      <= (state_d == c1908_lock_pkg::FAIL);
      lockout_q   <= (state_d == c1908_lock_pkg::LOCKOUT);
    end
  end

  assign key_ready = key_ready_q;
  assign key_out   = key_out_q;
  assign busy      = busy_q;
  assign unlocked  = unlocked_q;
  assign fail      = fail_q;
  assign lockout   = lockout_q;

  assign core_pi = (state_q == c1908_lock_pkg::UNLOCKED) ? func_pi : PI_W'(CHK_VEC);
  assign func_po = (state_q == c1908_lock_pkg::UNLOCKED) ? core_po : '0;

endmodule

// File: tb/tb_c1908_key_sequencer.sv
// tb/tb_c1908_key_sequencer.sv - directed self-checking bench for c1908_key_sequencer
module tb_c1908_key_sequencer;

  localparam logic [53:0] K_GOLD  = 54'h2A_F0C3_5A96_1B7E;
  localparam logic [53:0] K_BAD17 = K_GOLD ^ (54'h1 << 17);
  localparam logic [32:0] FUNC_PI = 33'h1_2345_6789;
  localparam logic [24:0] FUNC_PO = 25'h145_6789;

  logic        clk = 1'b0;
  logic        rst, start, key_bit, key_valid;
  logic        key_ready, busy, unlocked, fail, lockout;
  logic [53:0] key_out;
  logic [32:0] core_pi, func_pi;
  logic [24:0] core_po, func_po;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Core stand-in: transparent under the golden key, corrupted otherwise.
  assign core_po = core_pi[24:0] ^ ((key_out == K_GOLD) ? 25'h0 : 25'h155_5555);

  c1908_key_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_bit   (key_bit),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_out   (key_out),
    .core_pi   (core_pi),
    .core_po   (core_po),
    .func_pi   (func_pi),
    .func_po   (func_po),
    .busy      (busy),
    .unlocked  (unlocked),
    .fail      (fail),
    .lockout   (lockout)
  );

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_bit = 1'b0; func_pi = 33'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_load(input logic [53:0] key, input int max_gap, input int nbits,
                          input int poke_idx, output int lat);
    @(negedge clk); start = 1'b1;
    @(posedge clk); lat = 1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        key_valid = 1'b0;
        @(posedge clk); lat++;
        @(negedge clk);
      end
      key_valid = 1'b1; key_bit = key[i];
      if (i == poke_idx) start = 1'b1;
      @(posedge clk); lat++;
      @(negedge clk); start = 1'b0;
    end
    key_valid = 1'b0;
  endtask

  task automatic wait_result(inout int lat);
    int guard = 0;
    while (!(unlocked || fail || lockout) && guard < 30) begin
      @(posedge clk); lat++; #1; guard++;
    end
    n_tests++;
    if (guard >= 30) begin
      $display("FAIL result_timeout: got no result after %0d cycles want result", guard);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (key_ready !== 1'b0) begin $display("FAIL rst_key_ready: got %b want 0", key_ready); n_fail++; end
    n_tests++; if (key_out !== 54'h0) begin $display("FAIL rst_key_out: got %h want 0", key_out); n_fail++; end
    n_tests++; if (core_pi !== 33'h0) begin $display("FAIL rst_core_pi: got %h want 0", core_pi); n_fail++; end
    n_tests++; if (func_po !== 25'h0) begin $display("FAIL rst_func_po: got %h want 0", func_po); n_fail++; end
    n_tests++; if ({busy, unlocked, fail, lockout} !== 4'b0000) begin
      $display("FAIL rst_flags: got %b want 0000", {busy, unlocked, fail, lockout}); n_fail++; end
  endtask

  task automatic test_unlock();
    int lat;
    do_reset();
    run_load(K_GOLD, 0, 54, -1, lat);
    n_tests++; if (busy !== 1'b1) begin $display("FAIL unl_busy_settle: got %b want 1", busy); n_fail++; end
    n_tests++; if (key_out !== K_GOLD) begin $display("FAIL unl_key_out: got %h want %h", key_out, K_GOLD); n_fail++; end
    wait_result(lat);
    n_tests++; if (lat !== 58) begin $display("FAIL unl_latency: got %0d want 58", lat); n_fail++; end
    n_tests++; if (unlocked !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL unl_flags: got unlocked=%b busy=%b want 1 0", unlocked, busy); n_fail++; end
    func_pi = FUNC_PI; #1;
    n_tests++; if (core_pi !== FUNC_PI) begin $display("FAIL unl_core_pi: got %h want %h", core_pi, FUNC_PI); n_fail++; end
    n_tests++; if (func_po !== FUNC_PO) begin $display("FAIL unl_func_po: got %h want %h", func_po, FUNC_PO); n_fail++; end
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (unlocked !== 1'b1 || key_ready !== 1'b0 || key_out !== K_GOLD) begin
      $display("FAIL unl_start_ignored: got unlocked=%b key_ready=%b key_out=%h want 1 0 %h",
               unlocked, key_ready, key_out, K_GOLD); n_fail++; end
  endtask

  task automatic test_wrong_key();
    int lat;
    do_reset();
    func_pi = FUNC_PI;
    run_load(K_BAD17, 0, 54, -1, lat);
    wait_result(lat);
    n_tests++; if ({fail, unlocked, lockout} !== 3'b100) begin
      $display("FAIL bad_flags: got fail/unl/lock=%b want 100", {fail, unlocked, lockout}); n_fail++; end
    n_tests++; if (func_po !== 25'h0 || core_pi !== 33'h0) begin
      $display("FAIL bad_gating: got func_po=%h core_pi=%h want 0 0", func_po, core_pi); n_fail++; end
    n_tests++; if (key_out !== K_BAD17) begin $display("FAIL bad_key_kept: got %h want %h", key_out, K_BAD17); n_fail++; end
    run_load(K_GOLD, 0, 54, -1, lat);
    wait_result(lat);
    n_tests++; if (unlocked !== 1'b1 || fail !== 1'b0 || lat !== 58) begin
      $display("FAIL bad_retry: got unlocked=%b fail=%b lat=%0d want 1 0 58", unlocked, fail, lat); n_fail++; end
  endtask

  task automatic test_lockout();
    int lat;
    int hi = 0;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      run_load(K_BAD17 ^ 54'(t), 0, 54, -1, lat);
      wait_result(lat);
      if (t < 2) begin
        n_tests++; if (fail !== 1'b1 || lockout !== 1'b0) begin
          $display("FAIL lock_try%0d: got fail=%b lockout=%b want 1 0", t, fail, lockout); n_fail++; end
      end
    end
    n_tests++; if (lockout !== 1'b1 || key_out !== 54'h0) begin
      $display("FAIL lock_enter: got lockout=%b key_out=%h want 1 0", lockout, key_out); n_fail++; end
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (key_ready) hi++;
    end
    n_tests++; if (hi !== 0 || lockout !== 1'b1) begin
      $display("FAIL lock_sticky: got key_ready_cycles=%0d lockout=%b want 0 1", hi, lockout); n_fail++; end
  endtask

  task automatic test_gaps();
    int lat;
    do_reset();
    run_load(K_GOLD, 5, 54, -1, lat);
    wait_result(lat);
    n_tests++; if (key_out !== K_GOLD || unlocked !== 1'b1) begin
      $display("FAIL gap_unlock: got key_out=%h unlocked=%b want %h 1", key_out, unlocked, K_GOLD); n_fail++; end
  endtask

  task automatic test_reset_mid_load();
    int lat;
    do_reset();
    run_load(K_GOLD, 0, 30, -1, lat);
    n_tests++; if (key_ready !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL mid_loading: got key_ready=%b busy=%b want 1 1", key_ready, busy); n_fail++; end
    rst = 1'b1; #1;
    n_tests++; if ({key_ready, busy, unlocked, fail, lockout} !== 5'b0 || key_out !== 54'h0 ||
                   core_pi !== 33'h0 || func_po !== 25'h0) begin
      $display("FAIL mid_rst_values: got flags=%b key_out=%h core_pi=%h func_po=%h want 0",
               {key_ready, busy, unlocked, fail, lockout}, key_out, core_pi, func_po); n_fail++; end
    @(negedge clk); rst = 1'b0;
    run_load(K_GOLD, 0, 54, -1, lat);
    wait_result(lat);
    n_tests++; if (unlocked !== 1'b1 || lat !== 58) begin
      $display("FAIL mid_fresh_load: got unlocked=%b lat=%0d want 1 58", unlocked, lat); n_fail++; end
  endtask

  task automatic test_start_in_load();
    int lat;
    do_reset();
    run_load(K_GOLD, 0, 54, 20, lat);
    wait_result(lat);
    n_tests++; if (unlocked !== 1'b1 || lat !== 58 || key_out !== K_GOLD) begin
      $display("FAIL load_start_ignored: got unlocked=%b lat=%0d key_out=%h want 1 58 %h",
               unlocked, lat, key_out, K_GOLD); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong_key();
    test_lockout();
    test_gaps();
    test_reset_mid_load();
    test_start_in_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/c1908_key_sequencer.md
# c1908_key_sequencer

Unlock controller for the XOR-key-locked c1908 core. It receives the 54-bit key serially over a valid/ready handshake and holds it in a shadow register. It then applies the key to the core's KEYINPUT pins and runs a single known-answer check: it drives a fixed test vector and compares the core's 25 outputs against a golden response. Only after a pass does it connect the core's functional inputs and outputs; repeated failures lock the block out until reset.

## Interface
- KEY_W, 54, key width; must equal the number of core KEYINPUT pins
- PI_W, 33, core primary input width
- PO_W, 25, core primary output width
- CHK_VEC, 33'h0, test vector driven during the check
- CHK_RESP, 25'h0, golden core response to CHK_VEC under the correct key
- SETTLE_CYC, 2, wait cycles between key/vector application and sampling; range 1..15
- MAX_TRIES, 3, failed checks allowed before permanent lockout; range 1..7

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  single-cycle request to begin a key load
- key_bit  in  1  serial key data, LSB first
- key_valid  in  1  key_bit is valid
- key_ready  out  1  sequencer accepts a key bit this cycle
- key_out  out  KEY_W  to core KEYINPUT0..53; bit i drives KEYINPUTi
- core_pi  out  PI_W  to core primary inputs
- core_po  in  PO_W  from core primary outputs
- func_pi  in  PI_W  user functional inputs
- func_po  out  PO_W  user functional outputs; gated
- busy  out  1  high in LOAD, SETTLE and CHECK
- unlocked  out  1  check passed
- fail  out  1  last check failed
- lockout  out  1  MAX_TRIES failures reached; sticky until rst

## Operation
States:
- IDLE: on start, go to LOAD.
- LOAD: key_ready=1.
  - Each cycle with key_valid&key_ready shifts key_bit into the shadow register.
  - The first accepted bit lands at index 0.
  - The bit counter (6 bits) increments on each accept.
  - The cycle of the 54th accept copies the shadow register to key_out and moves to SETTLE.
  - key_valid gaps stall the load without limit.
- SETTLE: core_pi=CHK_VEC; down-counter runs SETTLE_CYC cycles, then go to CHECK.
- CHECK: core_pi=CHK_VEC; one cycle.
  - If core_po==CHK_RESP, go to UNLOCKED.
  - Otherwise increment tries (3 bits) and go to FAIL, or to LOCKOUT when tries reaches MAX_TRIES.
- UNLOCKED: core_pi=func_pi, func_po=core_po, unlocked=1. start is ignored.
- FAIL: fail=1; start re-enters LOAD and clears the bit counter and fail. key_out is retained until the next load completes.
- LOCKOUT: lockout=1, key_out forced to 0. All inputs ignored; only rst exits.

Gating and side rules:
- In every state except UNLOCKED: func_po=0 and core_pi=CHK_VEC.
- start outside IDLE and FAIL is ignored.
- tries is never cleared by a pass; only rst clears it.

## Timing
- Reset values:
  - Outputs: key_ready 0, key_out 0, core_pi CHK_VEC, func_po 0, busy 0, unlocked 0, fail 0, lockout 0.
  - Internal: state IDLE, counters 0, shadow register 0.
- All outputs are registered, except func_po and core_pi, which are combinational muxes selected by registered state.
- start sampled at edge n gives state LOAD and key_ready=1 in cycle n+1.
- key_out updates at the edge that accepts the 54th bit. busy stays high from then through SETTLE and CHECK.
- Sampling: core_po is sampled in the CHECK cycle, SETTLE_CYC+1 cycles after key_out changes.
- Result: unlocked or fail asserts on the following edge.
- Minimum unlock latency, start to unlocked, with key_valid held high: 1 + 54 + SETTLE_CYC + 1 cycles = 58 at default.
- The counter does not wrap; an accept with counter=53 is the terminal accept.
- rst during any state, including mid-LOAD: immediate return to reset values, and the partial key is discarded.

## Structure
- Package c1908_lock_pkg holds:
  - KEY_W/PI_W/PO_W constants
  - state enum {IDLE, LOAD, SETTLE, CHECK, UNLOCKED, FAIL, LOCKOUT}
  - counter width constants
- One sub-module, c1908_key_shreg: the serial-in shadow register with bit counter and a done pulse.
- The FSM, tries counter and gating muxes stay in the top module.

## Test plan
- Correct key K_GOLD, key_valid held high, SETTLE_CYC=2:
  - unlocked=1 exactly 58 cycles after start.
  - func_pi=33'h1_2345_6789 appears on core_pi, and the core response appears on func_po.
- Key with bit 17 flipped:
  - fail=1, unlocked=0, func_po=0, lockout=0.
  - A second start followed by K_GOLD gives unlocked=1.
- Three wrong keys with MAX_TRIES=3: lockout=1 and key_out=0 after the third check. A fourth start leaves key_ready=0 for 100 cycles.
- key_valid deasserted randomly for 0..5 cycles between bits of K_GOLD: key_out equals K_GOLD bit-exact, and unlocked=1.
- rst pulsed after 30 accepted bits:
  - All outputs return to reset values in the same cycle.
  - A fresh load of K_GOLD unlocks in 58 cycles.
- start pulsed during LOAD and during UNLOCKED: no effect on the bit counter, key_out or unlocked.
